jt49_dcadd: RTL
===============

# jt49_dcadd

DC restoration stage for the JT49 audio path: accepts signed, zero-centred PSG audio and produces unsigned 8-bit samples for a unipolar DAC or PWM output. This is the inverse of the DC-removal filter. To avoid audible pops, the block ramps the mid-scale bias up from 0 after reset and after unmute, and ramps it back down before going silent on mute. It sits at the output end of the filter chain, clocked by the same `cen` sample strobe.

## Interface
- `RAMP_SH`, default 4: each bias step takes 2^RAMP_SH `cen` pulses; a full ramp (0↔128) takes 128·2^RAMP_SH `cen` pulses.
- `clk`  in  1  system clock; one clock, all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cen`  in  1  sample clock enable; nothing advances while low.
- `din`  in  8  signed audio sample, two's complement.
- `mute`  in  1  level; high requests a ramp-down to silence.
- `dout`  out  8  unsigned output sample, registered.
- `settled`  out  1  registered; high while state is RUN.

## Operation
- State machine with states UP, RUN, DOWN and OFF; 8-bit bias register `bias` (range 0..128); RAMP_SH-bit prescaler `pre`.
- `pre` increments on every `cen` and wraps. A step occurs on a `cen` where `pre` is all ones (every `cen` when RAMP_SH=0).
- Effective audio `g` = `din` if `mute`=0 and state ∈ {UP, RUN}; otherwise 0.
- Sum `s` = sign-extended `g` (10 bits) + zero-extended `bias` (10 bits), using the pre-update `bias`.
- Saturation: `dout` <= 0 if `s` < 0, 255 if `s` > 255, else `s[7:0]`.
- Transitions, evaluated only on `cen`; `mute` has priority over ramp completion:
  - UP: if `mute`, go to DOWN. Else on a step `bias`++; if the new `bias` is 128, go to RUN.
  - RUN: if `mute`, go to DOWN; otherwise `bias` holds at 128.
  - DOWN: if not `mute`, go to UP with no step this cycle. Else on a step `bias`--; if the new `bias` is 0, go to OFF.
  - OFF: if not `mute`, go to UP. `bias` stays 0.
- Ramp reversal mid-ramp continues from the current `bias`; there is no jump. `pre` is not cleared on state changes.
- `settled` <= 1 on the edge that enters RUN. It goes to 0 on the edge that leaves RUN.

## Timing
- Reset values: state=UP, `bias`=0, `pre`=0, `dout`=0x00, `settled`=0.
- Reset asserted mid-ramp or mid-RUN returns all registers to the reset values immediately (asynchronous). The ramp restarts after release.
- `dout` latency: 1 `clk` edge qualified by `cen`. The `din` present on `cen` cycle n appears on `dout` after that edge, computed with `bias` as it was before that edge.
- Without `mute`, RUN is entered on `cen` pulse number 128·2^RAMP_SH after reset release, counting `cen` pulses from 1.
- `mute` is sampled only on `cen`. A `mute` pulse that falls between `cen` pulses is ignored.

## Configuration
- `JT49_DCADD_SAT_EN` defined: saturating output as described above.
- Undefined: the clamp logic is compiled out and `dout` = `s[7:0]` (wraps modulo 256). This suits upstream paths already guaranteed to stay within range. All other behaviour is identical.

## Test plan
- Ramp-up: RAMP_SH=2, `cen`=1 every clock, `din`=0, `mute`=0 after reset. Required: `bias` steps at `cen` #4, #8, …; `dout` reads 127 then 128 around `cen` #512; `settled` rises at `cen` #512 and `dout` stays 0x80.
- Offset and saturation in RUN, with `JT49_DCADD_SAT_EN` defined:
  - `din`=+5 → `dout`=133.
  - `din`=-128 → 0.
  - `din`=+127 → 255.
  - Undefine the macro and drive `din`=-128 with `bias`=128 → `dout`=0x00; `din`=+127 → 0xFF. Then force `bias`=10 in UP with `din`=-20 → `dout`=0xF6 (wrap) instead of 0x00.
- Mute: in RUN raise `mute`. Required: `settled` drops on the next `cen`, `din` is ignored, `dout` falls by 1 every 4 `cen` pulses, reaching 0 and state OFF after 512 `cen` pulses.
- Reversal: drop `mute` when `bias`=40 in DOWN. Required: state UP and `bias` climbs 41, 42, …; no jump in `dout`.
- Async reset in RUN: assert `rst` between clock edges. Required: `dout`=0 and `settled`=0 before the next `clk` edge; the full 512-`cen` ramp repeats after release.
- `cen` gating: hold `cen`=0 for 1000 clocks mid-ramp. Required: `bias`, `pre`, `dout` and the state are all frozen.

Source files
------------

// File: rtl/jt49_dcadd.sv
// DC restoration for the JT49 audio path: signed PSG audio plus a ramped mid-scale bias -> unsigned 8-bit.
// Optional macro JT49_DCADD_SAT_EN: clamp the sum to 0..255; when undefined the sum wraps modulo 256.
module jt49_dcadd #(
  parameter int RAMP_SH = 4,
  localparam int PW = (RAMP_SH > 0) ? RAMP_SH : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [7:0]    din,
  input  logic          mute,
  output logic [7:0]    dout,
  output logic          settled,
  output logic [1:0]    dbg_state_o,
  output logic [7:0]    dbg_bias_o,
  output logic [PW-1:0] dbg_pre_o
);

  // Handshake: none. All state advances only on a clk edge with cen high; mute is a level sampled there.
  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_RUN  = 2'd1,
    ST_DOWN = 2'd2,
    ST_OFF  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    bias_q;
  logic [PW-1:0] pre_q;
  logic [7:0]    dout_q;
  logic          settled_q;

  logic [7:0]    g;
  logic [7:0]    dout_d;
  logic          step;

  assign step = (RAMP_SH == 0) ? 1'b1 : &pre_q;

`ifdef JT49_DCADD_SAT_EN
  logic [9:0] s;
  always_comb begin
    g = 8'h00;
    if (!mute && (state_q == ST_UP || state_q == ST_RUN)) g = din;
    s = {{2{g[7]}}, g} + {2'b00, bias_q};
    // s[9] set means negative; s[8] alone means above full scale
    if (s[9])      dout_d = 8'h00;
    else if (s[8]) dout_d = 8'hFF;
    else           dout_d = s[7:0];
  end
`else
  always_comb begin
    g = 8'h00;
    if (!mute && (state_q == ST_UP || state_q == ST_RUN)) g = din;
    dout_d = g + bias_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_UP;
      bias_q    <= 8'd0;
      pre_q     <= '0;
      dout_q    <= 8'h00;
      settled_q <= 1'b0;
    end else if (cen) begin
      pre_q  <= pre_q + 1'b1;
      dout_q <= dout_d;
      case (state_q)
        ST_UP: begin
          if (mute) begin
            state_q   <= ST_DOWN;
            settled_q <= 1'b0;
          end else if (step) begin
            // A reversal can arrive here at full bias; never overshoot 128
            if (bias_q >= 8'd127) begin
              bias_q    <= 8'd128;
              state_q   <= ST_RUN;
              settled_q <= 1'b1;
            end else begin
              bias_q <= bias_q + 8'd1;
            end
          end
        end
        ST_RUN: begin
          if (mute) begin
            state_q   <= ST_DOWN;
            settled_q <= 1'b0;
          end
        end
        ST_DOWN: begin
          if (!mute) begin
            state_q <= ST_UP;
          end else if (step) begin
            if (bias_q <= 8'd1) begin
              bias_q  <= 8'd0;
              state_q <= ST_OFF;
            end else begin
              bias_q <= bias_q - 8'd1;
            end
          end
        end
        ST_OFF: begin
          if (!mute) state_q <= ST_UP;
        end
        default: state_q <= ST_UP;
      endcase
    end
  end

  assign dout        = dout_q;
  assign settled     = settled_q;
  assign dbg_state_o = state_q;
  assign dbg_bias_o  = bias_q;
  assign dbg_pre_o   = pre_q;

endmodule
